risc_mem_responder: RTL and testbench
=====================================

# risc_mem_responder

Memory-side responder for the pipelined RISC core: serves the core's instruction-fetch port and its data load/store port from on-chip flop arrays. Before execution, a byte-wide loader state machine fills instruction memory while holding the core in reset, then releases it. Sits beside the core in the top-level wrapper; the core's instruction and RAM ports connect directly to this block.

## Interface
Parameters:
- IMEM_DEPTH, 32, instruction words (≤256; word-addressed, matches the 8-bit fetch address)
- DMEM_DEPTH, 16, data words (word-addressed)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  in  8  fetch word address from the core
- imem_data  out  32  instruction at imem_addr
- dmem_addr  in  32  data word address (core ALU result)
- dmem_wdata  in  32  store data
- dmem_we  in  1  store strobe
- dmem_rdata  out  32  load data at dmem_addr
- ld_valid  in  1  loader byte valid
- ld_byte  in  8  loader byte, little-endian within each word
- ld_last  in  1  qualifies the final byte of the image
- ld_ready  out  1  loader may accept a byte
- core_rst_n  out  1  active-low reset to the core
- loaded_words  out  8  instruction words committed so far
- gpio_out  out  8  memory-mapped output register (see Configuration)

## Operation
- FSM states: LOAD, RUN. Reset enters LOAD. RUN exits only via rst_n.
- LOAD: ld_ready=1, core_rst_n=0. A byte is accepted on an edge with ld_valid&ld_ready and placed in byte lane byte_cnt (0..3) of a 32-bit assembly register.
- Commit: on the 4th accepted byte, or on any accepted byte with ld_last, the assembled word (unfilled upper lanes = 0) is written to imem[load_ptr] on that edge; load_ptr and loaded_words increment; byte_cnt and the assembly register clear.
- LOAD→RUN on the commit edge when ld_last is set or load_ptr reaches IMEM_DEPTH-1 before incrementing (array full). Bytes after a full array are never accepted (ld_ready=0).
- RUN: ld_ready=0; ld_valid ignored.
- Fetch: imem_data = imem[imem_addr] if imem_addr < IMEM_DEPTH, else 32'h0000_0013 (NOP). Unloaded in-range words return whatever was last written (imem has no reset).
- Data: dmem_rdata = dmem[dmem_addr] if dmem_addr < DMEM_DEPTH, else 0. Store writes dmem[dmem_addr] only when dmem_we is high, state is RUN and the address is in range; otherwise ignored. Upper address bits are compared, not truncated.
- Store and load to the same address in one cycle: dmem_rdata returns old data; new data is visible the next cycle.

## Timing
- Reset values: state=LOAD, core_rst_n=0, ld_ready=1, loaded_words=0, gpio_out=0, dmem all zero, byte_cnt=0, load_ptr=0.
- imem_data and dmem_rdata are combinational (zero latency), as the core samples them in the same cycle it presents the address.
- Stores and loader commits take effect on the rising edge.
- core_rst_n is registered: it rises one cycle after the edge that enters RUN, so the core's first fetch sees the fully committed image.
- rst_n asserted mid-load: the partial word is discarded, loaded_words=0, and loading restarts at word 0.

## Configuration
- RISC_MEM_MMIO_EN defined: word address 32'h0000_0080 maps to gpio_out. A store with dmem_we in RUN writes gpio_out <= dmem_wdata[7:0]. A load returns {24'b0, gpio_out}. This mapping takes priority over the dmem range check.
- Not defined: gpio_out is tied to 0, and address 0x80 decodes as an ordinary out-of-range address (reads 0, writes ignored).

## Structure
- Shared package: FSM state encoding (LOAD, RUN), the NOP constant 32'h0000_0013, and the MMIO address 32'h0000_0080.
- One sub-module: risc_mem_loader, which contains the FSM, byte_cnt, assembly register, load_ptr and core_rst_n register. It outputs a commit strobe with address and data. The arrays and read muxes stay in the top level.

## Test plan
- Reset then load 8 bytes 13 00 00 00 93 00 10 00 with ld_last on the 8th byte: imem[0]=0x00000013, imem[1]=0x00100093, loaded_words=2, and core_rst_n rises exactly one cycle after the RUN transition.
- Load 5 bytes AA BB CC DD 11 with ld_last on the 5th: imem[1]=0x00000011, RUN entered.
- Stream 4×IMEM_DEPTH+4 bytes without ld_last: RUN is entered on byte 4×IMEM_DEPTH, ld_ready=0 afterward, and the extra bytes are not accepted.
- In RUN, store 0xDEADBEEF to address 3 and then load address 3: reads 0xDEADBEEF. A store to address 0x1000 is ignored and a load from it returns 0. A fetch from address 200 returns 0x00000013.
- Drop rst_n after 2 bytes of the 2nd word: loaded_words=0, and reloading starts at imem[0].
- With RISC_MEM_MMIO_EN defined, store 0x1234_56A5 to 0x80: gpio_out=0xA5, and a load from 0x80 returns 0x000000A5. Without the macro, gpio_out stays 0.

Source files
------------

// File: rtl/risc_mem_pkg.sv
// Shared definitions for the RISC memory responder: loader states and fixed addresses.
package risc_mem_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } ld_state_t;

    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
    localparam logic [31:0] MMIO_ADDR = 32'h0000_0080;

endpackage

// File: rtl/risc_mem_loader.sv
// Byte-wide instruction image loader; holds the core in reset until the image is committed.
// Latency: commit strobe is combinational with the accepting byte; core_rst_n rises one cycle after RUN.
// Backpressure: ld_ready high only in LOAD; once the array fills or ld_last arrives, no further bytes are taken.
module risc_mem_loader
    import risc_mem_pkg::*;
#(
    parameter int IMEM_DEPTH = 32,
    parameter int IAW        = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ld_valid,
    input  logic [7:0]     ld_byte,
    input  logic           ld_last,
    output logic           ld_ready,
    output logic           core_rst_n,
    output logic           run,
    output logic [7:0]     loaded_words,
    output logic           commit_vld,
    output logic [IAW-1:0] commit_addr,
    output logic [31:0]    commit_dat
);

    ld_state_t   state, state_nxt;
    logic [1:0]  byte_cnt, byte_cnt_nxt;
    logic [31:0] asm_q, asm_nxt;
    logic [8:0]  load_ptr, load_ptr_nxt;
    logic        core_rst_q;
    logic        accept;
    logic [31:0] merged;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_LOAD;
            byte_cnt   <= '0;
            asm_q      <= '0;
            load_ptr   <= '0;
            core_rst_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_cnt   <= byte_cnt_nxt;
            asm_q      <= asm_nxt;
            load_ptr   <= load_ptr_nxt;
            // Lags the state by one edge so the core never fetches a half-written image.
            core_rst_q <= (state == ST_RUN);
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        asm_nxt      = asm_q;
        load_ptr_nxt = load_ptr;
        ld_ready     = (state == ST_LOAD);
        accept       = ld_valid & ld_ready;
        merged       = asm_q | ({24'b0, ld_byte} << {byte_cnt, 3'b000});
        commit_vld   = accept & ((byte_cnt == 2'd3) | ld_last);
        commit_dat   = merged;

        if (accept) begin
            if (commit_vld) begin
                byte_cnt_nxt = '0;
                asm_nxt      = '0;
                load_ptr_nxt = load_ptr + 9'd1;
                if (ld_last || (load_ptr == 9'(IMEM_DEPTH - 1))) begin
                    state_nxt = ST_RUN;
                end
            end else begin
                byte_cnt_nxt = byte_cnt + 2'd1;
                asm_nxt      = merged;
            end
        end
    end

    assign run          = (state == ST_RUN);
    assign core_rst_n   = core_rst_q;
    assign loaded_words = load_ptr[7:0];
    assign commit_addr  = load_ptr[IAW-1:0];

endmodule

// File: rtl/risc_mem_responder.sv
// Instruction/data memory responder for the RISC core; optional GPIO register via RISC_MEM_MMIO_EN.
// Latency: fetch and load data are combinational; stores and loader commits land on the rising edge.
// Backpressure: none toward the core; the loader stalls only by dropping ld_ready after the image.
module risc_mem_responder
    import risc_mem_pkg::*;
#(
    parameter int IMEM_DEPTH = 32,
    parameter int DMEM_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  imem_addr,
    output logic [31:0] imem_data,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_we,
    output logic [31:0] dmem_rdata,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        core_rst_n,
    output logic [7:0]  loaded_words,
    output logic [7:0]  gpio_out
);

    localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    logic           run;
    logic           commit_vld;
    logic [IAW-1:0] commit_addr;
    logic [31:0]    commit_dat;
    logic           imem_in_range;
    logic           dmem_in_range;
    logic           is_mmio;

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];

    risc_mem_loader #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .IAW        (IAW)
    ) u_loader (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_valid     (ld_valid),
        .ld_byte      (ld_byte),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .core_rst_n   (core_rst_n),
        .run          (run),
        .loaded_words (loaded_words),
        .commit_vld   (commit_vld),
        .commit_addr  (commit_addr),
        .commit_dat   (commit_dat)
    );

    // Instruction store is written only by the loader and intentionally has no reset.
    always_ff @(posedge clk) begin
        if (commit_vld) begin
            imem[commit_addr] <= commit_dat;
        end
    end

    assign imem_in_range = ({24'b0, imem_addr} < 32'(IMEM_DEPTH));
    assign imem_data     = imem_in_range ? imem[imem_addr[IAW-1:0]] : NOP_INSN;

    // Full 32-bit compare so aliased upper address bits never hit the array.
    assign dmem_in_range = (dmem_addr < 32'(DMEM_DEPTH));

`ifdef RISC_MEM_MMIO_EN
    logic [7:0] gpio_q;

    assign is_mmio = (dmem_addr == MMIO_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_q <= '0;
        end else if (dmem_we && run && is_mmio) begin
            gpio_q <= dmem_wdata[7:0];
        end
    end

    assign gpio_out = gpio_q;
`else
    assign is_mmio  = 1'b0;
    assign gpio_out = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                dmem[i] <= '0;
            end
        end else if (dmem_we && run && !is_mmio && dmem_in_range) begin
            dmem[dmem_addr[DAW-1:0]] <= dmem_wdata;
        end
    end

    always_comb begin
        dmem_rdata = '0;
        if (is_mmio) begin
            dmem_rdata = {24'b0, gpio_out};
        end else if (dmem_in_range) begin
            dmem_rdata = dmem[dmem_addr[DAW-1:0]];
        end
    end

endmodule

// File: tb/tb_risc_mem_responder.sv
// Directed bench for risc_mem_responder: a byte-queue reference model checked every cycle,
// plus literal expectations taken from hand-computed load images and store sequences.
module tb_risc_mem_responder;

    localparam int IMEM_DEPTH = 32;
    localparam int DMEM_DEPTH = 16;
`ifdef RISC_MEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [31:0] dmem_rdata;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic        core_rst_n;
    logic [7:0]  loaded_words;
    logic [7:0]  gpio_out;

    risc_mem_responder #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .DMEM_DEPTH (DMEM_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_we      (dmem_we),
        .dmem_rdata   (dmem_rdata),
        .ld_valid     (ld_valid),
        .ld_byte      (ld_byte),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .core_rst_n   (core_rst_n),
        .loaded_words (loaded_words),
        .gpio_out     (gpio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: bytes queue up per word; a word lands when four are held or the last arrives.
    bit          m_run;
    bit          m_crst;
    int          m_words;
    logic [7:0]  m_q[$];
    logic [31:0] m_imem [IMEM_DEPTH];
    bit          m_known [IMEM_DEPTH];
    logic [31:0] m_dmem [DMEM_DEPTH];
    logic [7:0]  m_gpio;
    bit          was_run;
    logic [31:0] m_word;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run   = 1'b0;
            m_crst  = 1'b0;
            m_words = 0;
            m_q.delete();
            foreach (m_dmem[i]) m_dmem[i] = '0;
            m_gpio  = '0;
        end else begin
            was_run = m_run;
            m_crst  = was_run;
            if (was_run) begin
                if (dmem_we) begin
                    if (MMIO && dmem_addr == 32'h80) m_gpio = dmem_wdata[7:0];
                    else if (dmem_addr < 32'(DMEM_DEPTH)) m_dmem[dmem_addr[3:0]] = dmem_wdata;
                end
            end else if (ld_valid) begin
                m_q.push_back(ld_byte);
                if (m_q.size() == 4 || ld_last) begin
                    m_word = '0;
                    foreach (m_q[i]) m_word = m_word | (32'(m_q[i]) << (8 * i));
                    m_imem[m_words]  = m_word;
                    m_known[m_words] = 1'b1;
                    m_words++;
                    m_q.delete();
                    if (ld_last || m_words == IMEM_DEPTH) m_run = 1'b1;
                end
            end
        end
    end

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        if (MMIO && a == 32'h80) return {24'b0, m_gpio};
        if (a < 32'(DMEM_DEPTH)) return m_dmem[a[3:0]];
        return 32'h0;
    endfunction

    always @(negedge clk) begin
        check("ld_ready", 32'(ld_ready), 32'(!m_run));
        check("core_rst_n", 32'(core_rst_n), 32'(m_crst));
        check("loaded_words", 32'(loaded_words), m_words & 32'hFF);
        check("gpio_out", 32'(gpio_out), 32'(m_gpio));
        check("dmem_rdata", dmem_rdata, exp_rdata(dmem_addr));
        if (imem_addr >= 8'(IMEM_DEPTH)) check("imem_nop", imem_data, 32'h0000_0013);
        else if (m_known[imem_addr[4:0]]) check("imem_data", imem_data, m_imem[imem_addr[4:0]]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        dmem_we  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        dmem_addr  = a;
        dmem_wdata = d;
        dmem_we    = 1'b1;
        tick();
        dmem_we = 1'b0;
    endtask

    logic [7:0] img1 [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    logic [7:0] img2 [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};

    initial begin
        rst_n = 1'b0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
        imem_addr = '0; dmem_addr = '0; dmem_wdata = '0; dmem_we = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rst_ld_ready", 32'(ld_ready), 32'h1);
        check("rst_core_rst_n", 32'(core_rst_n), 32'h0);
        check("rst_loaded_words", 32'(loaded_words), 32'h0);
        check("rst_gpio", 32'(gpio_out), 32'h0);
        check("rst_dmem0", dmem_rdata, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        store(32'd5, 32'hCAFE_F00D);
        dmem_addr = 32'd5;
        @(negedge clk);
        check("store_in_load_ignored", dmem_rdata, 32'h0);
        tick();

        // Two-word image with ld_last on the final byte.
        foreach (img1[i]) send(img1[i], i == 7);
        @(negedge clk);
        check("t1_run_ready", 32'(ld_ready), 32'h0);
        check("t1_crst_still_low", 32'(core_rst_n), 32'h0);
        check("t1_words", 32'(loaded_words), 32'h2);
        tick();
        @(negedge clk);
        check("t1_crst_rises", 32'(core_rst_n), 32'h1);
        tick();
        imem_addr = 8'd0;
        @(negedge clk);
        check("t1_imem0", imem_data, 32'h0000_0013);
        tick();
        imem_addr = 8'd1;
        @(negedge clk);
        check("t1_imem1", imem_data, 32'h0010_0093);
        tick();

        // Partial final word: upper lanes zero.
        do_reset();
        foreach (img2[i]) send(img2[i], i == 4);
        @(negedge clk);
        check("t2_run_ready", 32'(ld_ready), 32'h0);
        check("t2_words", 32'(loaded_words), 32'h2);
        tick();
        imem_addr = 8'd0;
        @(negedge clk);
        check("t2_imem0", imem_data, 32'hDDCC_BBAA);
        tick();
        imem_addr = 8'd1;
        @(negedge clk);
        check("t2_imem1", imem_data, 32'h0000_0011);
        tick();

        // Fill the array without ld_last; the trailing bytes must be refused.
        do_reset();
        for (int i = 0; i < 4 * IMEM_DEPTH + 4; i++) begin
            send(8'(i), 1'b0);
            if (i == 4 * IMEM_DEPTH - 2) begin
                @(negedge clk);
                check("t3_ready_before_full", 32'(ld_ready), 32'h1);
                tick();
            end
            if (i == 4 * IMEM_DEPTH - 1) begin
                @(negedge clk);
                check("t3_ready_at_full", 32'(ld_ready), 32'h0);
                check("t3_words_at_full", 32'(loaded_words), 32'd32);
                tick();
            end
        end
        @(negedge clk);
        check("t3_words_after_extra", 32'(loaded_words), 32'd32);
        check("t3_ready_after_extra", 32'(ld_ready), 32'h0);
        tick();
        imem_addr = 8'd31;
        @(negedge clk);
        check("t3_imem31", imem_data, 32'h7F7E_7D7C);
        tick();
        imem_addr = 8'd0;
        @(negedge clk);
        check("t3_imem0", imem_data, 32'h0302_0100);
        tick();

        // Data port in RUN.
        store(32'd3, 32'hDEAD_BEEF);
        dmem_addr = 32'd3;
        @(negedge clk);
        check("t4_load3", dmem_rdata, 32'hDEAD_BEEF);
        tick();
        dmem_wdata = 32'h1111_1111;
        dmem_we    = 1'b1;
        @(negedge clk);
        check("t4_same_cycle_old", dmem_rdata, 32'hDEAD_BEEF);
        tick();
        dmem_we = 1'b0;
        @(negedge clk);
        check("t4_next_cycle_new", dmem_rdata, 32'h1111_1111);
        tick();
        store(32'h0000_1000, 32'h7777_7777);
        dmem_addr = 32'h0000_1000;
        @(negedge clk);
        check("t4_oor_load", dmem_rdata, 32'h0);
        tick();
        store(32'h1000_0003, 32'h5555_5555);
        dmem_addr = 32'd3;
        @(negedge clk);
        check("t4_upper_bits_alias", dmem_rdata, 32'h1111_1111);
        tick();
        imem_addr = 8'd200;
        @(negedge clk);
        check("t4_fetch_oor_nop", imem_data, 32'h0000_0013);
        tick();
        store(32'h0000_0080, 32'h1234_56A5);
        dmem_addr = 32'h0000_0080;
        @(negedge clk);
        check("t6_gpio", 32'(gpio_out), MMIO ? 32'hA5 : 32'h0);
        check("t6_mmio_load", dmem_rdata, MMIO ? 32'hA5 : 32'h0);
        tick();

        // Reset in the middle of the second word.
        do_reset();
        @(negedge clk);
        check("t5_gpio_reset", 32'(gpio_out), 32'h0);
        tick();
        for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
        @(negedge clk);
        check("t5_words_mid", 32'(loaded_words), 32'h1);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_words_cleared", 32'(loaded_words), 32'h0);
        check("t5_ready_reset", 32'(ld_ready), 32'h1);
        tick();
        rst_n = 1'b1;
        send(8'hA0, 1'b1);
        @(negedge clk);
        check("t5_words_reload", 32'(loaded_words), 32'h1);
        tick();
        imem_addr = 8'd0;
        @(negedge clk);
        check("t5_imem0_reload", imem_data, 32'h0000_00A0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
